fifo_wptr_full: RTL
===================

// Module: fifo_wptr_full
// PURPOSE
// - Write-domain pointer/flag stage of the async FIFO. Sits directly upstream of
//   the 2-flop gray synchronizer that carries the write pointer into the read domain.
// - Keeps the binary and gray write pointers and produces the memory write address/strobe.
// - Compares its next gray pointer against the read pointer (already synchronized into
//   wr_clk) to generate a registered, pessimistic wr_full.
// PARAMETERS
// - ADDR_WIDTH          4  : memory address bits; depth = 2**ADDR_WIDTH; legal >= 2
// - ALMOST_FULL_MARGIN  2  : wr_almost_full asserts when free slots <= this value
//                            (used only with FIFO_ALMOST_FULL_EN); legal 1..depth-1
// PORTS
// - wr_clk          in   1             write-domain clock
// - wr_rst          in   1             async reset, active-high; deassert sync to wr_clk
// - wr_en           in   1             write request
// - wr_rptr_sync    in   ADDR_WIDTH+1  gray read pointer, already in the wr_clk domain
// - wr_mem_we       out  1             memory write strobe = wr_en & ~wr_full (comb)
// - wr_addr         out  ADDR_WIDTH    memory write address = wr_bin[ADDR_WIDTH-1:0]
// - wr_ptr          out  ADDR_WIDTH+1  registered gray write pointer, to synchronizer
// - wr_full         out  1             registered full flag
// - wr_almost_full  out  1             registered almost-full flag
// - wr_overflow     out  1             registered 1-cycle pulse: write attempted while full
// BEHAVIOUR
// - Reset (async, any time, incl. mid-burst): wr_bin, wr_ptr, wr_full, wr_almost_full,
//   wr_overflow = 0. wr_addr = 0 and wr_mem_we = 0 follow immediately.
// - Read side must be reset in the same event. No data is preserved.
// - Every wr_clk edge:
//   - bin_next  = wr_bin + (wr_en & ~wr_full)   [ADDR_WIDTH+1 bits, wraps modulo]
//   - gray_next = (bin_next >> 1) ^ bin_next
//   - wr_bin <= bin_next; wr_ptr <= gray_next (registered, glitch-free; one bit
//     changes per increment)
//   - wr_full <= (gray_next == {~wr_rptr_sync[AW:AW-1], wr_rptr_sync[AW-2:0]})
//   - wr_overflow <= wr_en & wr_full
// - Latency:
//   - The write that fills the last slot makes wr_full = 1 on that same edge; there
//     is no over-write window.
//   - A read frees space only after it crosses the synchronizer (>= 2 wr_clk plus rd
//     edge). wr_full therefore deasserts late, never early.
//   - Full is re-evaluated every edge, with or without a write.
// - Writes while full: pointer holds, wr_mem_we = 0, data dropped, wr_overflow pulses.
// - Wrap: address wraps depth-1 -> 0, pointer MSB toggles. The extra MSB
//   distinguishes full from empty. No false full at wrap.
// - wr_rptr_sync is trusted gray; the block does not re-synchronize it.
// CONFIGURATION
// - FIFO_ALMOST_FULL_EN defined:
//   - rbin = gray-to-binary(wr_rptr_sync); occ_next = bin_next - rbin (mod 2**(AW+1)).
//   - wr_almost_full <= (occ_next >= 2**AW - ALMOST_FULL_MARGIN). Registered, same
//     timing as wr_full. Pessimistic like wr_full.
// - FIFO_ALMOST_FULL_EN undefined: port remains; wr_almost_full tied to 0. No
//   gray-to-binary logic or subtractor is built.
// TESTING (ADDR_WIDTH=4, depth 16)
// - Reset: assert wr_rst between edges mid-burst -> all registered outputs 0 before
//   the next edge; wr_addr 0.
// - Fill: wr_rptr_sync=0, wr_en=1 for 16 cycles -> wr_ptr gray 0,1,3,2,6,...;
//   wr_full=1 at the 16th edge; wr_ptr=5'b11000; wr_mem_we=1 exactly 16 times.
// - Overflow: keep wr_en=1 3 more cycles while full -> wr_ptr holds 5'b11000;
//   wr_mem_we=0; wr_overflow high 3 cycles, 0 after wr_en drops.
// - Space return: from full, set wr_rptr_sync=5'b00001 -> wr_full=0 next edge.
//   One write -> wr_full=1 again, wr_addr went 0 -> 1.
// - Wrap: 40 writes, reader model keeping occupancy <= 8 -> wr_addr 15 -> 0 twice;
//   wr_full never asserts; MSB toggles at writes 16 and 32.
// - Almost-full: FIFO_ALMOST_FULL_EN, margin 2, rptr=0 -> wr_almost_full=1 at the
//   14th write edge. Rebuilt without the macro, the same stimulus keeps it 0.

Source files
------------

// File: rtl/fifo_wptr_full_if.sv
// Write-side bus of the async FIFO write-pointer stage: the request and the
// synchronized read pointer go in; memory strobe/address, the gray pointer and
// the flags come out.
interface fifo_wptr_full_if #(
   parameter int unsigned ADDR_WIDTH = 4
);
   logic                  wr_en;
   logic [ADDR_WIDTH:0]   wr_rptr_sync;
   logic                  wr_mem_we;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic [ADDR_WIDTH:0]   wr_ptr;
   logic                  wr_full;
   logic                  wr_almost_full;
   logic                  wr_overflow;

   // Writer / environment side
   modport master (
      output wr_en,
      output wr_rptr_sync,
      input  wr_mem_we,
      input  wr_addr,
      input  wr_ptr,
      input  wr_full,
      input  wr_almost_full,
      input  wr_overflow
   );

   // Pointer stage side
   modport slave (
      input  wr_en,
      input  wr_rptr_sync,
      output wr_mem_we,
      output wr_addr,
      output wr_ptr,
      output wr_full,
      output wr_almost_full,
      output wr_overflow
   );
endinterface

// File: rtl/fifo_wptr_full.sv
// Write-domain pointer/flag stage of the async FIFO.
// Holds the binary and gray write pointers, drives the memory write
// address/strobe and produces a registered, pessimistic full flag by comparing
// the next gray pointer against the read pointer already synchronized into
// wr_clk. The gray pointer is registered so the downstream 2-flop synchronizer
// only ever sees single-bit transitions.
// Optional feature: define FIFO_ALMOST_FULL_EN to build the almost-full flag
// (gray-to-binary of the read pointer plus an occupancy subtractor); without it
// wr_almost_full is tied low and none of that logic exists.
module fifo_wptr_full #(
   parameter int unsigned ADDR_WIDTH         = 4,
   parameter int unsigned ALMOST_FULL_MARGIN = 2
) (
   input logic            wr_clk,
   input logic            wr_rst,
   fifo_wptr_full_if.slave bus
);

   localparam int unsigned PW = ADDR_WIDTH + 1;

   // Parameter legality, caught at elaboration
   if (ADDR_WIDTH < 2) begin : g_aw_chk
      $error("fifo_wptr_full: ADDR_WIDTH must be >= 2");
   end
   if ((ALMOST_FULL_MARGIN < 1) || (ALMOST_FULL_MARGIN > (1 << ADDR_WIDTH) - 1)) begin : g_margin_chk
      $error("fifo_wptr_full: ALMOST_FULL_MARGIN must be in 1..depth-1");
   end

   logic [PW-1:0] wr_bin;
   logic [PW-1:0] ptr_q;
   logic          full_q;
   logic          overflow_q;

   logic          write_ok;
   logic [PW-1:0] bin_next;
   logic [PW-1:0] gray_next;
   logic [PW-1:0] full_cmp;
   logic          full_next;

   // Next pointer and full compare: full when the next gray pointer equals the
   // read pointer with its two MSBs inverted (one lap ahead).
   always_comb begin
      write_ok  = bus.wr_en & ~full_q;
      bin_next  = wr_bin + PW'(write_ok);
      gray_next = (bin_next >> 1) ^ bin_next;
      full_cmp  = {~bus.wr_rptr_sync[PW-1:PW-2], bus.wr_rptr_sync[PW-3:0]};
      full_next = (gray_next == full_cmp);
   end

   // Pointer, full and overflow registers
   always_ff @(posedge wr_clk or posedge wr_rst) begin
      if (wr_rst) begin
         wr_bin     <= '0;
         ptr_q      <= '0;
         full_q     <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         wr_bin     <= bin_next;
         ptr_q      <= gray_next;
         full_q     <= full_next;
         overflow_q <= bus.wr_en & full_q;
      end
   end

`ifdef FIFO_ALMOST_FULL_EN
   localparam logic [PW-1:0] AF_THRESH = PW'((1 << ADDR_WIDTH) - ALMOST_FULL_MARGIN);

   logic [PW-1:0] rbin;
   logic [PW-1:0] occ_next;
   logic          af_next;
   logic          af_q;

   // Occupancy after this edge, from the (stale) synchronized read pointer
   always_comb begin
      rbin         = '0;
      rbin[PW-1]   = bus.wr_rptr_sync[PW-1];
      for (int i = PW - 2; i >= 0; i--) begin
         rbin[i] = rbin[i+1] ^ bus.wr_rptr_sync[i];
      end
      occ_next = bin_next - rbin;
      af_next  = (occ_next >= AF_THRESH);
   end

   // Almost-full register, same timing as full
   always_ff @(posedge wr_clk or posedge wr_rst) begin
      if (wr_rst) begin
         af_q <= 1'b0;
      end else begin
         af_q <= af_next;
      end
   end

   assign bus.wr_almost_full = af_q;
`else
   assign bus.wr_almost_full = 1'b0;
`endif

   // Strobe is suppressed while reset is held so no write leaks out mid-reset
   assign bus.wr_mem_we   = bus.wr_en & ~full_q & ~wr_rst;
   assign bus.wr_addr     = wr_bin[ADDR_WIDTH-1:0];
   assign bus.wr_ptr      = ptr_q;
   assign bus.wr_full     = full_q;
   assign bus.wr_overflow = overflow_q;

endmodule
